// File: rtl/cnt_arb_pkg.sv
// Shared definitions for the interval-counter arbiter: FSM state encoding,
// default sizes and the round-robin pick helper.
package cnt_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CW      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Returns the first asserted request scanning last+1, last+2, ... modulo n.
    // The scan runs backwards and overwrites, so the nearest candidate wins.
    // Falls back to last when nothing is requesting (caller ignores it then).
    function automatic int rr_pick(input logic [7:0] req, input int last, input int n);
        int idx;
        rr_pick = last;
        for (int k = n; k >= 1; k--) begin
            idx = (last + k) % n;
            if (req[idx[2:0]]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/interval_counter.sv
// Interval counter shared by all requesters. Synchronous clear wins over
// enable; hit flags that the count has reached the sampled target.
module interval_counter
    import cnt_arb_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] target,
    output logic [CW-1:0] count,
    output logic          hit
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear has priority, otherwise increment when enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign hit   = (count_q == target);

endmodule

// File: rtl/cnt_interval_arbiter.sv
// Round-robin arbiter that lends one interval counter to NUM_REQ requesters.
// Each grant runs (dur+1) counting cycles, then pulses done to the owner.
// Optional build macro CNT_ARB_ABORT_EN: when defined, an owner that drops
// req during RUN aborts its interval (no done pulse).
module cnt_interval_arbiter
    import cnt_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CW      = DEF_CW,
    parameter int IDW     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*CW-1:0] dur,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy,
    output logic [IDW-1:0]        owner,
    output logic [CW-1:0]         count_out
);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [CW-1:0]      target_q, target_d;

    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_hit;
    logic [IDW-1:0]     pick_idx;
    logic               abort;

    assign pick_idx = IDW'(rr_pick(8'(req), int'(last_q), NUM_REQ));

`ifdef CNT_ARB_ABORT_EN
    assign abort = ~req[owner_q];
`else
    assign abort = 1'b0;
`endif

    interval_counter #(
        .CW(CW)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .target (target_q),
        .count  (count_out),
        .hit    (cnt_hit)
    );

    // Next-state and registered-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = busy_q;
        owner_d  = owner_q;
        last_d   = last_q;
        target_d = target_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (|req) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    last_d            = pick_idx;
                    target_d          = dur[int'(pick_idx)*CW +: CW];
                    busy_d            = 1'b1;
                    state_d           = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    // last already points at this owner, so it drops to lowest priority
                    grant_d = '0;
                    busy_d  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (cnt_hit) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset parks the pointer so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            owner_q  <= '0;
            last_q   <= IDW'(NUM_REQ - 1);
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            target_q <= target_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_cnt_interval_arbiter.sv
// Scoreboard bench for cnt_interval_arbiter: directed stimulus pushes the
// expected grants/dones, a negedge monitor pops and compares them.
module tb_cnt_interval_arbiter;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*CW-1:0] dur;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [IDW-1:0]  owner;
    logic [CW-1:0]   count_out;

    typedef struct {
        int idx;
        int dur;
    } exp_t;

    exp_t gq[$];
    exp_t dq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    bit   mon_en   = 1'b0;

    cnt_interval_arbiter #(
        .NUM_REQ(N),
        .CW     (CW),
        .IDW    (IDW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .dur      (dur),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .owner    (owner),
        .count_out(count_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", name, cycle);
    endtask

    task automatic push(input int idx, input int d, input bit expect_done);
        exp_t e;
        e.idx = idx;
        e.dur = d;
        gq.push_back(e);
        if (expect_done) dq.push_back(e);
    endtask

    task automatic set_dur(input int i, input int v);
        logic [CW-1:0] v4;
        v4 = v[CW-1:0];
        dur[i*CW +: CW] = v4;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(input logic [N-1:0] mask);
        int t = 0;
        while ((grant & mask) == '0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if ((grant & mask) == '0) fail_now("wait_grant");
    endtask

    task automatic wait_done(input logic [N-1:0] mask, input bit drop);
        int t = 0;
        while ((done & mask) == '0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if ((done & mask) == '0) fail_now("wait_done");
        if (drop) req = req & ~mask;
    endtask

    // Monitor: pops expectations when a grant starts or a done pulse appears.
    initial begin
        logic [N-1:0] prev_grant = '0;
        int  grant_cyc     = 0;
        int  last_done_cyc = -10;
        bit  after_done    = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (after_done) begin
                    chk("post_done_grant", 32'(grant), 32'd0);
                    chk("post_done_busy", 32'(busy), 32'd0);
                    after_done = 1'b0;
                end
                if (grant != '0 && prev_grant == '0) begin
                    if (gq.size() == 0) begin
                        chk("unexpected_grant", 32'(grant), 32'd0);
                    end else begin
                        e = gq.pop_front();
                        $display("grant: owner=%0d grant=%b cycle=%0d", owner, grant, cycle);
                        chk("grant_vec", 32'(grant), 32'(1 << e.idx));
                        chk("grant_owner", 32'(owner), 32'(e.idx));
                        chk("grant_busy", 32'(busy), 32'd1);
                        chk("idle_gap", 32'(cycle - last_done_cyc >= 2), 32'd1);
                    end
                    grant_cyc = cycle;
                end
                if (done != '0) begin
                    if (dq.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = dq.pop_front();
                        $display("done: vec=%b count=%0d cycle=%0d", done, count_out, cycle);
                        chk("done_vec", 32'(done), 32'(1 << e.idx));
                        chk("done_count", 32'(count_out), 32'(e.dur));
                        chk("done_latency", 32'(cycle - grant_cyc), 32'(e.dur + 1));
                        chk("done_grant_held", 32'(grant), 32'(1 << e.idx));
                    end
                    last_done_cyc = cycle;
                    after_done    = 1'b1;
                end
            end
            prev_grant = grant;
        end
    end

    // Directed stimulus.
    initial begin
        reset = 1'b1;
        req   = '0;
        dur   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // 1: single request, dur=3, count walks 0..3
        set_dur(0, 3);
        push(0, 3, 1'b1);
        req = 4'b0001;
        wait_grant(4'b0001);
        for (int i = 0; i < 4; i++) begin
            chk("run_count", 32'(count_out), 32'(i));
            @(negedge clk);
        end
        wait_done(4'b0001, 1'b1);
        repeat (2) @(negedge clk);

        // 2: simultaneous req0/req2 after reset, req0 first
        do_reset();
        set_dur(0, 1);
        set_dur(2, 1);
        push(0, 1, 1'b1);
        push(2, 1, 1'b1);
        req = 4'b0101;
        wait_done(4'b0001, 1'b1);
        wait_done(4'b0100, 1'b1);
        repeat (2) @(negedge clk);

        // 3: all requesters held, dur=0, order 0,1,2,3,0
        do_reset();
        dur = '0;
        push(0, 0, 1'b1);
        push(1, 0, 1'b1);
        push(2, 0, 1'b1);
        push(3, 0, 1'b1);
        push(0, 0, 1'b1);
        req = 4'b1111;
        wait_done(4'b0001, 1'b0);
        wait_done(4'b0010, 1'b0);
        wait_done(4'b0100, 1'b0);
        wait_done(4'b1000, 1'b0);
        wait_done(4'b0001, 1'b0);
        req = '0;
        repeat (2) @(negedge clk);

        // 4: maximum duration, no wrap
        set_dur(3, 15);
        push(3, 15, 1'b1);
        req = 4'b1000;
        wait_done(4'b1000, 1'b1);
        repeat (2) @(negedge clk);

        // 5: reset on the 3rd RUN cycle of a dur=7 interval
        do_reset();
        set_dur(0, 7);
        push(0, 7, 1'b0);
        req = 4'b0001;
        wait_grant(4'b0001);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(count_out), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        set_dur(0, 0);
        set_dur(1, 0);
        push(0, 0, 1'b1);
        push(1, 0, 1'b1);
        req = 4'b0011;
        wait_done(4'b0001, 1'b1);
        wait_done(4'b0010, 1'b1);
        repeat (2) @(negedge clk);

        // 6: owner 1 drops req on RUN cycle 2 of dur=5, req2 pending
        do_reset();
        set_dur(1, 5);
        set_dur(2, 0);
`ifdef CNT_ARB_ABORT_EN
        push(1, 5, 1'b0);
`else
        push(1, 5, 1'b1);
`endif
        push(2, 0, 1'b1);
        req = 4'b0010;
        wait_grant(4'b0010);
        req = 4'b0110;
        @(negedge clk);
        req = 4'b0100;
`ifdef CNT_ARB_ABORT_EN
        @(negedge clk);
        chk("abort_grant", 32'(grant), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
`endif
        wait_done(4'b0100, 1'b1);
        repeat (3) @(negedge clk);

        chk("grants_left", 32'(gq.size()), 32'd0);
        chk("dones_left", 32'(dq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt_interval_arbiter.md
Name: cnt_interval_arbiter

Overview:
- Shares one CW-bit interval counter among NUM_REQ requesters.
- Each requester asks for a timed interval of (dur+1) clock cycles.
- A round-robin arbiter grants the counter to one requester at a time, runs the count, and pulses that requester's done.
- Sits between the lab control logic and the counter datapath; it is the sole sequencer of the counter's clear/enable.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CW, 4, counter and duration width in bits.
- IDW, 2, owner index width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; held until done.
- dur  input  NUM_REQ*CW  packed durations; slice i = dur[i*CW +: CW].
- grant  output  NUM_REQ  one-hot; owner of the counter; all zero when idle.
- done  output  NUM_REQ  one-cycle pulse to the owner at interval end.
- busy  output  1  high in RUN and DONE.
- owner  output  IDW  index of current or last owner.
- count_out  output  CW  live counter value.

Behaviour:
- Reset (clk edge with reset=1) sets:
  - state=IDLE; grant=0; done=0; busy=0; count_out=0; owner=0.
  - RR pointer last=NUM_REQ-1, so requester 0 has highest priority first.
- Reset has priority over every other event, including mid-RUN.
- All outputs are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req != 0, select the first asserted req scanning last+1, last+2, ... modulo NUM_REQ.
  - Next cycle: grant[w]=1, owner=w, last=w, target=dur slice w (sampled in this IDLE cycle), count=0, state=RUN.
  - If req == 0, stay in IDLE.
- RUN:
  - If count==target, go to DONE. Otherwise count=count+1.
  - RUN lasts target+1 cycles; dur=0 gives exactly 1 RUN cycle.
  - count never wraps, because target <= 2^CW-1.
- DONE:
  - done[owner]=1 for exactly this cycle; grant is still held.
  - Next cycle: grant=0, count=0, state=IDLE.
- Latency: req sampled in IDLE at cycle t gives grant at t+1, done at t+2+dur, and the next arbitration no earlier than t+3+dur.
- Back-to-back: after DONE there is always one IDLE cycle before the next grant.
- A requester still asserting req after its done becomes lowest priority in the next round, so no requester starves.
- req changes of non-owners during RUN/DONE are ignored; only IDLE arbitrates.
- dur changes after sampling are ignored.
- Owner dropping req during RUN: behaviour is set by the optional feature below.
- Multiple simultaneous reqs: exactly one grant, chosen per the RR rule above.

Optional Feature:
- Macro: CNT_ARB_ABORT_EN.
- Defined:
  - If the owner's req is 0 in any RUN cycle, the next state is IDLE.
  - That transition sets grant=0 and count=0; no done pulse is issued.
  - last is still updated to the aborted owner.
  - An abort and count==target in the same cycle resolve as an abort.
- Undefined: the owner dropping req is ignored; the interval completes and done is pulsed normally.

Decomposition:
- Shared package cnt_arb_pkg holds:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default CW and NUM_REQ constants;
  - an rr_pick function returning the index of the next requester.
- Natural sub-module: interval_counter.
  - Ports: clk, reset, clr, en, target -> count, hit.
  - Synchronous clear takes priority over enable.
  - The arbiter FSM drives clr and en.

Test Plan:
1. req=4'b0001, dur0=3 -> grant=0001 one cycle later; count_out 0,1,2,3 over 4 RUN cycles; done=0001 for one cycle; grant=0 the following cycle.
2. req=4'b0101 simultaneous after reset, dur0=dur2=1 -> req0 granted first, done0; after the IDLE cycle req2 is granted, done2; owner sequence 0 then 2.
3. All four req held continuously, all dur=0 -> grant order 0,1,2,3,0; each interval occupies 3 cycles (RUN, DONE, IDLE); no requester is granted twice before the others.
4. req=4'b1000, dur3=15 -> 16 RUN cycles; count_out reaches 15 with no wrap; done3 pulses once.
5. Reset asserted on the 3rd RUN cycle of a dur=7 interval -> next cycle grant=0, busy=0, count_out=0, no done; the next arbitration starts from requester 0.
6. With CNT_ARB_ABORT_EN: owner 1 drops req on RUN cycle 2 of dur=5 -> grant=0 next cycle, no done1; with req2 pending, req2 is granted after the IDLE cycle. Without the macro: the interval completes and done1 pulses after 6 RUN cycles.
